// File: rtl/opram_pkg.sv
// Shared constants and types for the operand RAM arbiter.
package opram_pkg;
  localparam int OPRAM_ADDR_W = 3;
  localparam int OPRAM_DATA_W = 8;
  localparam int OPRAM_DEPTH  = 8;

  typedef enum logic [1:0] {S_RST, S_INIT, S_RUN} state_t;

  localparam int REQ_CORE = 0;
  localparam int REQ_HOST = 1;
endpackage

// File: rtl/opram_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, priority flips to the
// requester not granted most recently; no grants while accept is low.
module opram_rr_arb2
  import opram_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic prefer_host;  // 1 = host wins a tie

  always_comb begin
    gnt = 2'b00;
    if (accept) begin
      if (req[REQ_CORE] && (!req[REQ_HOST] || !prefer_host)) begin
        gnt[REQ_CORE] = 1'b1;
      end else if (req[REQ_HOST]) begin
        gnt[REQ_HOST] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prefer_host <= 1'b0;
    end else if (gnt[REQ_CORE]) begin
      prefer_host <= 1'b1;
    end else if (gnt[REQ_HOST]) begin
      prefer_host <= 1'b0;
    end
  end

endmodule

// File: rtl/opram_arbiter.sv
// Shares the single-port operand RAM between core and host; optional clear after reset.
// Grant in the request cycle, read data one cycle later; requests are held until granted.
module opram_arbiter
  import opram_pkg::*;
#(
  parameter int              ADDR_W     = OPRAM_ADDR_W,
  parameter int              DATA_W     = OPRAM_DATA_W,
  parameter int              DEPTH      = OPRAM_DEPTH,
  parameter bit              INIT_CLEAR = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              init_done,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_ce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_oce,
  output logic              ram_reset,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [1:0]        gnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_RST;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        S_RST: begin
          clr_cnt <= '0;
          if (INIT_CLEAR) begin
            state <= S_INIT;
          end else begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        S_INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        S_RUN:   init_done <= 1'b1;
        default: state <= S_RST;
      endcase
    end
  end

  opram_rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({r1_req, r0_req}),
    .accept  (state == S_RUN),
    .gnt     (gnt)
  );

  assign r0_gnt = gnt[REQ_CORE];
  assign r1_gnt = gnt[REQ_HOST];

  always_comb begin
    ram_ce  = 1'b0;
    ram_wre = 1'b0;
    ram_ad  = '0;
    ram_din = '0;
    if (state == S_INIT) begin
      ram_ce  = 1'b1;
      ram_wre = 1'b1;
      ram_ad  = clr_cnt;
      ram_din = INIT_VALUE;
    end else if (gnt[REQ_CORE]) begin
      ram_ce  = 1'b1;
      ram_wre = r0_we;
      ram_ad  = r0_addr;
      ram_din = r0_wdata;
    end else if (gnt[REQ_HOST]) begin
      ram_ce  = 1'b1;
      ram_wre = r1_we;
      ram_ad  = r1_addr;
      ram_din = r1_wdata;
    end
  end

  // The RAM output is unregistered in bypass mode, so only the flag is pipelined.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
    end else begin
      r0_rvalid <= gnt[REQ_CORE] & ~r0_we;
      r1_rvalid <= gnt[REQ_HOST] & ~r1_we;
    end
  end

  assign rdata     = ram_dout;
  assign ram_oce   = 1'b1;
  assign ram_reset = 1'b0;

endmodule

// File: tb/tb_opram_arbiter.sv
// Directed plus random stimulus against a cycle-count/last-winner model of the arbiter.
module tb_opram_arbiter;
  import opram_pkg::*;

  localparam logic [7:0] INIT_V = 8'h00;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       init_done;
  logic       r0_req, r0_we, r1_req, r1_we;
  logic [2:0] r0_addr, r1_addr;
  logic [7:0] r0_wdata, r1_wdata;
  logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [7:0] rdata;
  logic       ram_ce, ram_wre, ram_oce, ram_reset;
  logic [2:0] ram_ad;
  logic [7:0] ram_din, ram_dout;

  opram_arbiter #(.INIT_CLEAR(1'b1), .INIT_VALUE(INIT_V)) dut (
    .clk(clk), .reset_n(reset_n), .init_done(init_done),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .rdata(rdata), .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_ad(ram_ad),
    .ram_din(ram_din), .ram_oce(ram_oce), .ram_reset(ram_reset), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM environment, bypass read: dout changes on the read edge.
  logic [7:0] ram_mem [8];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) ram_mem[ram_ad] <= ram_din;
      else         ram_dout <= ram_mem[ram_ad];
    end
  end

  // Reference model: cycles since reset release, last winner, memory image, pending reply.
  int         t;
  int         last_g;
  int         last_grant;
  logic [7:0] mmem [8];
  bit         pend_v [2];
  logic [7:0] pend_d;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already set; returns at the next falling edge.
  task automatic cycle(input bit rst_mid = 1'b0);
    int         g;
    bit         run, clr;
    logic       e_we;
    logic [2:0] e_ad;
    logic [7:0] e_din;
    #1;
    run = reset_n && (t >= 9);
    clr = reset_n && (t >= 1) && (t <= 8);
    g = -1;
    if (run) begin
      if (r0_req && r1_req) g = (last_g == 0) ? 1 : 0;
      else if (r0_req)      g = 0;
      else if (r1_req)      g = 1;
    end
    e_we = 1'b0; e_ad = 3'd0; e_din = 8'h00;
    if (clr) begin
      e_we = 1'b1; e_ad = 3'(t - 1); e_din = INIT_V;
    end else if (g == 0) begin
      e_we = r0_we; e_ad = r0_addr; e_din = r0_wdata;
    end else if (g == 1) begin
      e_we = r1_we; e_ad = r1_addr; e_din = r1_wdata;
    end
    chk("init_done", init_done, run);
    chk("r0_gnt", r0_gnt, g == 0);
    chk("r1_gnt", r1_gnt, g == 1);
    chk("ram_ce", ram_ce, clr || g >= 0);
    chk("ram_wre", ram_wre, e_we);
    chk("ram_ad", ram_ad, e_ad);
    chk("ram_din", ram_din, e_din);
    chk("r0_rvalid", r0_rvalid, pend_v[0]);
    chk("r1_rvalid", r1_rvalid, pend_v[1]);
    if (pend_v[0] || pend_v[1]) chk("rdata", rdata, pend_d);
    chk("ram_oce", ram_oce, 1'b1);
    if (rst_mid) reset_n = 1'b0;
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    if (g >= 0 && !e_we) begin
      pend_v[g] = 1'b1;
      pend_d    = mmem[e_ad];
    end
    if (clr || (g >= 0 && e_we)) mmem[e_ad] = e_din;
    last_grant = g;
    if (!reset_n) begin
      t = 0; last_g = 1; pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    end else begin
      t++;
      if (g >= 0) last_g = g;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_random();
    if (!r0_req || last_grant == 0) begin
      r0_req = ($urandom_range(0, 3) != 0);
      r0_we = $urandom_range(0, 1) == 1; r0_addr = 3'($urandom_range(0, 7)); r0_wdata = 8'($urandom);
    end
    if (!r1_req || last_grant == 1) begin
      r1_req = ($urandom_range(0, 3) != 0);
      r1_we = $urandom_range(0, 1) == 1; r1_addr = 3'($urandom_range(0, 7)); r1_wdata = 8'($urandom);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    for (int i = 0; i < 8; i++) begin
      ram_mem[i] = 8'($urandom);
      mmem[i]    = 8'hxx;
    end
    t = 0; last_g = 1; last_grant = -1; pend_v[0] = 0; pend_v[1] = 0; pend_d = 8'h00;
    @(negedge clk);
    repeat (2) cycle();
    reset_n = 1'b1;

    // Host requests during the clear; granted on the first run cycle.
    r1_req = 1; r1_we = 0; r1_addr = 3'd4;
    for (int i = 0; i < 11; i++) begin
      cycle();
      if (last_grant == 1) r1_req = 0;
    end

    r0_req = 1; r0_we = 0; r0_addr = 3'd5; cycle();
    r0_req = 0; cycle();

    r0_req = 1; r0_we = 1; r0_addr = 3'd3; r0_wdata = 8'hA5; cycle();
    r0_we = 0; cycle();
    r0_req = 0; cycle();

    r0_req = 1; r0_we = 0; r0_addr = 3'd1;
    r1_req = 1; r1_we = 0; r1_addr = 3'd2;
    repeat (4) cycle();
    r0_req = 0; r1_req = 0; cycle();

    r1_req = 1; r1_we = 1; r1_addr = 3'd7; r1_wdata = 8'h3C; cycle();
    r1_req = 0; r0_req = 1; r0_we = 0; r0_addr = 3'd7; cycle();
    r0_req = 0; cycle();

    repeat (400) begin
      drive_random();
      cycle();
    end

    // Reset lands between a read grant and its response.
    r0_req = 1; r0_we = 0; r0_addr = 3'd3; r1_req = 0;
    cycle(1'b1);
    r0_req = 0;
    repeat (2) cycle();
    reset_n = 1'b1;
    r0_req = 1; r0_we = 0; r0_addr = 3'd3;
    r1_req = 1; r1_we = 0; r1_addr = 3'd6;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (last_grant == 0) r0_req = 0;
      if (last_grant == 1) r1_req = 0;
    end

    repeat (200) begin
      drive_random();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/opram_arbiter.md
Name: opram_arbiter

Overview:
- Sequences and shares the 8x8 single-port operand RAM (Gowin SP macro, bypass read mode) between two requesters: r0 = core datapath, r1 = debug/host loader.
- After reset, optionally clears every RAM entry before any requester is granted.
- Then grants one access per cycle using round-robin arbitration.
- Returns read data with a fixed 1-cycle latency from grant.

Parameters:
- ADDR_W, 3, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 8, number of entries; must equal 2**ADDR_W.
- INIT_CLEAR, 1, 1 = write INIT_VALUE to all entries after reset; 0 = go straight to RUN.
- INIT_VALUE, 8'h00, value written during clear.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- init_done  out  1  high once the block is in RUN.
- r0_req  in  1  requester 0 access request; held until granted.
- r0_we  in  1  1 = write, 0 = read; stable while r0_req is high.
- r0_addr  in  ADDR_W  requester 0 address; stable while r0_req is high.
- r0_wdata  in  DATA_W  requester 0 write data; stable while r0_req is high.
- r0_gnt  out  1  1-cycle pulse: RAM samples r0's access this cycle.
- r0_rvalid  out  1  read data for r0 on rdata this cycle.
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid  same as r0, for requester 1.
- rdata  out  DATA_W  shared read data; meaningful only when r0_rvalid or r1_rvalid is high.
- ram_ce  out  1  RAM clock enable.
- ram_wre  out  1  RAM write enable.
- ram_ad  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_oce  out  1  tied 1.
- ram_reset  out  1  tied 0; the RAM output register is never reset.
- ram_dout  in  DATA_W  RAM read data; valid the cycle after a read edge.

Behaviour:
- States: S_RST, S_INIT, S_RUN.
  - reset_n low asynchronously forces S_RST, init counter = 0, rr pointer = r0-preferred, rvalid regs = 0.
- S_RST: all outputs inactive (ram_ce=0, gnt=0, rvalid=0, init_done=0). Next cycle goes to S_INIT if INIT_CLEAR, else S_RUN.
- S_INIT: each cycle drives ram_ce=1, ram_wre=1, ram_ad=counter, ram_din=INIT_VALUE.
  - Counter increments each cycle; after writing address DEPTH-1, goes to S_RUN (exactly DEPTH cycles in S_INIT).
  - No grants are issued; requests stay pending.
- S_RUN: init_done=1. Arbitration is combinational on the current-cycle req signals.
  - Only one req high: that requester is granted.
  - Both high: grant the requester not granted most recently (rr pointer). The pointer updates on every grant.
  - On a grant: gnt pulses, ram_ce=1, and ram_wre/ram_ad/ram_din = the granted requester's we/addr/wdata, all in the same cycle.
  - No grant: ram_ce=0, ram_wre=0, ram_ad/ram_din hold 0.
  - Requester drops req in the cycle after gnt, or keeps it high for a new access; back-to-back grants to one requester are allowed when the other is idle.
- Read response: a read granted in cycle N gives rN_rvalid=1 in cycle N+1, with rdata = ram_dout, driven combinationally from the RAM.
  - The rvalid flag is registered from (gnt & ~we).
  - Writes produce no response.
- Throughput: one access per cycle. Reads pipeline fully (grant N, N+1 -> rvalid N+1, N+2).
- Hazards:
  - Write in cycle N, then read of the same address in N+1 returns the new data.
  - Both requesters writing one address in consecutive cycles: last write wins.
- Reset mid-operation: an outstanding rvalid is dropped, no response is issued after reset, and the clear sequence restarts at address 0.
- req while init_done=0: not granted; it is granted on the first S_RUN cycle.

Decomposition:
- Shared package opram_pkg:
  - OPRAM_ADDR_W=3, OPRAM_DATA_W=8, OPRAM_DEPTH=8.
  - State typedef {S_RST, S_INIT, S_RUN}.
  - Requester id constants REQ_CORE=0, REQ_HOST=1.
- One sub-module is natural: opram_rr_arb2, a 2-way round-robin arbiter (req[1:0], grant-accept -> gnt[1:0], pointer register).
- FSM and datapath muxing stay in the top module; the RAM itself stays outside the block.

Test Plan:
- Reset clear: release reset_n, INIT_CLEAR=1 -> ram_ce=ram_wre=1 for exactly 8 cycles with ram_ad 0..7 and din 00, then init_done=1; a subsequent r0 read of addr 5 returns 00.
- Single requester: r0 writes A5 to addr 3 (gnt same cycle), then reads addr 3 -> r0_rvalid one cycle after the read grant, rdata=A5, r1_rvalid stays 0.
- Contention: r0 and r1 both hold reads (addr 1, addr 2) for 4 cycles after init -> grants alternate r0,r1,r0,r1; each rvalid follows its grant by one cycle with the correct data.
- Write-then-read: r1 writes 3C to addr 7 in cycle N, r0 reads addr 7 in N+1 -> rdata=3C in N+2.
- Early request: r1_req high during S_INIT -> no r1_gnt until the cycle init_done first reads 1, then granted.
- Reset mid-read: read granted in cycle N, reset_n low before edge N+1 -> rvalid stays 0; after release the clear restarts at addr 0 and the rr pointer prefers r0.
